// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: TX/RX state encodings, default line settings and
// the clocks-per-bit derivation, so transmitter and receiver agree on timing.
package uart_rx_pkg;

  localparam int CLK_FREQ_DEFAULT = 10_000_000;
  localparam int BAUDRATE_DEFAULT = 115_200;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input; both flops
// reset to 1 so a reset never looks like a falling edge downstream.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1_reg;
  logic ff2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1_reg <= 1'b1;
      ff2_reg <= 1'b1;
    end else begin
      ff1_reg <= d;
      ff2_reg <= ff1_reg;
    end
  end

  assign q = ff2_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a per-bit clock counter, one-cycle
// data_valid / frame_error strobes, and a BREAK state for a held-low line.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int clk_freq = CLK_FREQ_DEFAULT,
  parameter int baudrate = BAUDRATE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       input_rx,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy,
  output logic [1:0] led
);

  localparam int clks_per_bit = calc_clks_per_bit(clk_freq, baudrate);
  localparam int half_bit     = (clks_per_bit - 1) / 2;
  localparam logic [15:0] BIT_LAST  = 16'(clks_per_bit - 1);
  localparam logic [15:0] HALF_LAST = 16'(half_bit);

  logic       rx_s;
  rx_state_t  state_reg, state_next;
  logic [15:0] clk_count_reg, clk_count_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] data_byte_reg, data_byte_next;
  logic       data_valid_reg, data_valid_next;
  logic       frame_error_reg, frame_error_next;
  logic       led_err_reg, led_err_next;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (input_rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RX_IDLE;
      clk_count_reg   <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      data_byte_reg   <= '0;
      data_valid_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      led_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      clk_count_reg   <= clk_count_next;
      bit_idx_reg     <= bit_idx_next;
      shift_reg       <= shift_next;
      data_byte_reg   <= data_byte_next;
      data_valid_reg  <= data_valid_next;
      frame_error_reg <= frame_error_next;
      led_err_reg     <= led_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    clk_count_next   = clk_count_reg;
    bit_idx_next     = bit_idx_reg;
    shift_next       = shift_reg;
    data_byte_next   = data_byte_reg;
    data_valid_next  = 1'b0;
    frame_error_next = 1'b0;
    led_err_next     = led_err_reg;

    case (state_reg)
      RX_IDLE: begin
        clk_count_next = '0;
        bit_idx_next   = '0;
        if (!rx_s) state_next = RX_START;
      end
      RX_START: begin
        // A line that is high again at mid-start-bit was only a glitch.
        if (clk_count_reg == HALF_LAST) begin
          clk_count_next = '0;
          state_next     = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          clk_count_next = clk_count_reg + 16'd1;
        end
      end
      RX_DATA: begin
        if (clk_count_reg == BIT_LAST) begin
          clk_count_next          = '0;
          shift_next[bit_idx_reg] = rx_s;
          bit_idx_next            = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = RX_STOP;
        end else begin
          clk_count_next = clk_count_reg + 16'd1;
        end
      end
      RX_STOP: begin
        if (clk_count_reg == BIT_LAST) begin
          clk_count_next = '0;
          if (rx_s) begin
            data_byte_next  = shift_reg;
            data_valid_next = 1'b1;
            state_next      = RX_IDLE;
          end else begin
            frame_error_next = 1'b1;
            led_err_next     = 1'b1;
            state_next       = RX_BREAK;
          end
        end else begin
          clk_count_next = clk_count_reg + 16'd1;
        end
      end
      RX_BREAK: begin
        // Swallow a held-low line so it reports one error, not a frame stream.
        clk_count_next = '0;
        if (rx_s) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign data_byte   = data_byte_reg;
  assign data_valid  = data_valid_reg;
  assign frame_error = frame_error_reg;
  assign busy        = (state_reg != RX_IDLE);
  assign led         = {~led_err_reg, ~busy};

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: frames, glitch, framing error, break,
// back-to-back frames and reset mid-frame, checked with immediate assertions.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       input_rx;
  logic [7:0] data_byte;
  logic       data_valid;
  logic       frame_error;
  logic       busy;
  logic [1:0] led;

  int checks   = 0;
  int failures = 0;

  uart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .input_rx    (input_rx),
    .data_byte   (data_byte),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy),
    .led         (led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int         v_cnt = 0, fe_cnt = 0, v_cyc = 0, v_cyc_prev = 0, fe_cyc = 0;
  int         overlap = 0, long_pulse = 0;
  logic [7:0] v_byte = 8'h00, v_byte_prev = 8'h00;
  logic       dv_d = 1'b0, fe_d = 1'b0;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      v_cnt++;
      v_cyc_prev  = v_cyc;
      v_cyc       = cyc;
      v_byte_prev = v_byte;
      v_byte      = data_byte;
    end
    if (frame_error === 1'b1) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (data_valid === 1'b1 && dv_d) long_pulse++;
    if (frame_error === 1'b1 && fe_d) long_pulse++;
    if (data_valid === 1'b1 && frame_error === 1'b1) overlap++;
    dv_d = (data_valid === 1'b1);
    fe_d = (frame_error === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    input_rx = b;
    idle_cycles(86);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    $display("frame sent data=%02h stop=%0b start_cyc=%0d", d, stop, t0);
  endtask

  int t0, t1;

  initial begin
    rst      = 1'b1;
    input_rx = 1'b1;
    idle_cycles(3);
    check("rst_data_byte", 32'(data_byte), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_frame_error", 32'(frame_error), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_led", 32'(led), 32'h3);
    rst = 1'b0;
    idle_cycles(10);

    // 0x55, one good stop bit
    send_frame(8'h55, 1'b1, t0);
    idle_cycles(20);
    check("t1_valid_count", 32'(v_cnt), 32'd1);
    check("t1_byte", 32'(v_byte), 32'h55);
    check("t1_valid_cycle", 32'(v_cyc), 32'(t0 + 820));
    check("t1_no_fe", 32'(fe_cnt), 32'd0);

    // 20-cycle glitch
    t0 = cyc;
    input_rx = 1'b0;
    idle_cycles(20);
    input_rx = 1'b1;
    check("t2_busy_in_start", 32'(busy), 32'h1);
    idle_cycles(27);
    check("t2_busy_cleared", 32'(busy), 32'h0);
    check("t2_no_valid", 32'(v_cnt), 32'd1);
    check("t2_no_fe", 32'(fe_cnt), 32'd0);
    $display("glitch done start_cyc=%0d", t0);

    // 0xA3 with a low stop bit
    send_frame(8'hA3, 1'b0, t0);
    input_rx = 1'b1;
    idle_cycles(10);
    check("t3_fe_count", 32'(fe_cnt), 32'd1);
    check("t3_fe_cycle", 32'(fe_cyc), 32'(t0 + 820));
    check("t3_byte_kept", 32'(data_byte), 32'h55);
    check("t3_led1", 32'(led[1]), 32'h0);
    check("t3_no_valid", 32'(v_cnt), 32'd1);
    check("t3_idle", 32'(busy), 32'h0);

    // line held low for 2000 cycles
    t0 = cyc;
    input_rx = 1'b0;
    idle_cycles(1500);
    check("t4_busy_break", 32'(busy), 32'h1);
    check("t4_fe_once", 32'(fe_cnt), 32'd2);
    idle_cycles(500);
    input_rx = 1'b1;
    check("t4_busy_at_release", 32'(busy), 32'h1);
    idle_cycles(5);
    check("t4_idle_after", 32'(busy), 32'h0);
    check("t4_fe_still_once", 32'(fe_cnt), 32'd2);
    check("t4_led1_held", 32'(led[1]), 32'h0);
    $display("break done start_cyc=%0d", t0);

    // back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    idle_cycles(20);
    check("t5_valid_count", 32'(v_cnt), 32'd3);
    check("t5_first_byte", 32'(v_byte_prev), 32'h00);
    check("t5_second_byte", 32'(v_byte), 32'hFF);
    check("t5_gap", 32'(v_cyc - v_cyc_prev), 32'd860);
    check("t5_second_cycle", 32'(v_cyc), 32'(t0 + 1680));

    // reset during data bit 3 of a 0x0F frame
    t0 = cyc;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    input_rx = 1'b1;
    idle_cycles(40);
    rst = 1'b1;
    idle_cycles(3);
    check("t6_rst_byte", 32'(data_byte), 32'h00);
    check("t6_rst_led", 32'(led), 32'h3);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_valid", 32'(data_valid), 32'h0);
    rst = 1'b0;
    idle_cycles(800);
    check("t6_no_pulse", 32'(v_cnt), 32'd3);
    check("t6_no_fe", 32'(fe_cnt), 32'd2);
    check("t6_still_idle", 32'(busy), 32'h0);
    $display("reset abort done start_cyc=%0d", t0);
    send_frame(8'h3C, 1'b1, t1);
    idle_cycles(20);
    check("t6_valid_count", 32'(v_cnt), 32'd4);
    check("t6_byte", 32'(v_byte), 32'h3C);
    check("t6_valid_cycle", 32'(v_cyc), 32'(t1 + 820));
    check("t6_led", 32'(led), 32'h3);

    check("no_overlap", 32'(overlap), 32'd0);
    check("single_cycle_pulses", 32'(long_pulse), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
